// File: rtl/spi_master_pkg.sv
// Shared definitions for the multi-chip-select Wishbone SPI master:
// register indices, CTRL/STATUS bit positions, frame width encoding and FSM states.
package spi_master_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_DIV    = 3'd2;
  localparam logic [2:0] REG_CS     = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_CPHA   = 0;
  localparam int CTRL_CPOL   = 1;
  localparam int CTRL_LSB    = 2;
  localparam int CTRL_WLO    = 3;
  localparam int CTRL_WHI    = 4;
  localparam int CTRL_IRQ_EN = 8;

  // Only the defined CTRL bits are stored; the rest read back as 0.
  localparam logic [8:0] CTRL_MASK = 9'h11F;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  localparam logic [1:0] WIDTH_8     = 2'd0;
  localparam logic [1:0] WIDTH_16    = 2'd1;
  localparam logic [1:0] WIDTH_32    = 2'd2;
  localparam logic [1:0] WIDTH_8_ALT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } spi_state_e;

  // Number of bits in a frame for a CTRL width code.
  function automatic logic [5:0] frame_bits(input logic [1:0] enc);
    case (enc)
      WIDTH_16:             return 6'd16;
      WIDTH_32:             return 6'd32;
      WIDTH_8, WIDTH_8_ALT: return 6'd8;
      default:              return 6'd8;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI shift engine: half-period divider, IDLE/SHIFT/TAIL sequencer,
// transmit/receive shift registers and edge counter for one frame.
module spi_shift_engine
  import spi_master_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cpha,
  input  logic                 cpol,
  input  logic                 lsb_first,
  input  logic [1:0]           width_sel,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 start,
  input  logic [31:0]          tx_data,
  input  logic                 miso,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          rx_data,
  output logic                 sclk,
  output logic                 mosi
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  spi_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [6:0]           edge_q;
  logic [31:0]          tx_sr, rx_sr;
  logic [31:0]          load_val, rx_final;
  logic [5:0]           nbits, pad;
  logic                 tick, launch, sample_edge, last_edge;

  function automatic logic head_bit(input logic [31:0] v, input logic lsb);
    return lsb ? v[0] : v[31];
  endfunction

  function automatic logic [31:0] shift_tx(input logic [31:0] v, input logic lsb);
    return lsb ? {1'b0, v[31:1]} : {v[30:0], 1'b0};
  endfunction

  function automatic logic [31:0] shift_rx(input logic [31:0] v, input logic b, input logic lsb);
    return lsb ? {b, v[31:1]} : {v[30:0], b};
  endfunction

  assign nbits = frame_bits(width_sel);
  assign pad   = 6'd32 - nbits;

  // MSB-first frames are left-justified so the head is always bit 31;
  // LSB-first frames are masked so nothing beyond the frame leaks onto MOSI.
  assign load_val = lsb_first ? (tx_data & (32'hFFFF_FFFF >> pad)) : (tx_data << pad);
  assign rx_final = lsb_first ? (rx_sr >> pad) : rx_sr;

  assign tick   = (state_q != ST_IDLE) && (cnt_q == '0);
  assign launch = start && (state_q == ST_IDLE);
  // Even edge index is the leading edge; CPHA picks which edge samples.
  assign sample_edge = (~edge_q[0]) ^ cpha;
  assign last_edge   = (edge_q == ({nbits, 1'b0} - 7'd1));
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_TAIL) && tick;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state sequencing: a frame runs 2*W edges then one quiet half-period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (launch)            state_d = ST_SHIFT;
      ST_SHIFT: if (tick && last_edge) state_d = ST_TAIL;
      ST_TAIL:  if (tick)              state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Divider, shift registers, SCK/MOSI drive and RX capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (launch) begin
      cnt_q  <= div;
      edge_q <= '0;
      rx_sr  <= '0;
      if (!cpha) begin
        mosi  <= head_bit(load_val, lsb_first);
        tx_sr <= shift_tx(load_val, lsb_first);
      end else begin
        mosi  <= 1'b0;
        tx_sr <= load_val;
      end
    end else if (state_q == ST_IDLE) begin
      sclk <= cpol;
      mosi <= 1'b0;
    end else begin
      cnt_q <= tick ? div : (cnt_q - DIV_ONE);
      if (tick) begin
        if (state_q == ST_SHIFT) begin
          sclk   <= ~sclk;
          edge_q <= edge_q + 7'd1;
          if (sample_edge) begin
            rx_sr <= shift_rx(rx_sr, miso, lsb_first);
          end else begin
            mosi  <= head_bit(tx_sr, lsb_first);
            tx_sr <= shift_tx(tx_sr, lsb_first);
          end
        end else begin
          sclk    <= cpol;
          mosi    <= 1'b0;
          rx_data <= rx_final;
        end
      end
    end
  end

endmodule

// File: rtl/wb_spi_master_mc.sv
// Wishbone classic slave wrapping the SPI shift engine: bus decode,
// CTRL/DIV/CS/STATUS registers, overrun detection and the done interrupt.
module wb_spi_master_mc
  import spi_master_pkg::*;
#(
  parameter int NUM_CS    = 4,
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              irq_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_n_o
);

  logic [8:0]           ctrl_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [NUM_CS-1:0]    cs_q;
  logic                 done_q, ovr_q;
  logic                 req, wr, start;
  logic                 eng_busy, eng_done;
  logic [31:0]          rx_data, rdata;
  logic                 unused_sel;

  // Byte enables carry no meaning here: every write is a full word.
  assign unused_sel = ^wb_sel_i;

  assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr    = req & wb_we_i;
  assign start = wr && (wb_adr_i == REG_DATA) && !eng_busy;

  assign spi_cs_n_o = ~cs_q;

  spi_shift_engine #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_engine (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpha      (ctrl_q[CTRL_CPHA]),
    .cpol      (ctrl_q[CTRL_CPOL]),
    .lsb_first (ctrl_q[CTRL_LSB]),
    .width_sel (ctrl_q[CTRL_WHI:CTRL_WLO]),
    .div       (div_q),
    .start     (start),
    .tx_data   (wb_dat_i),
    .miso      (spi_miso_i),
    .busy      (eng_busy),
    .done      (eng_done),
    .rx_data   (rx_data),
    .sclk      (spi_sclk_o),
    .mosi      (spi_mosi_o)
  );

  // Read mux; unmapped words read as zero.
  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      REG_DATA:   rdata = rx_data;
      REG_CTRL:   rdata[8:0] = ctrl_q;
      REG_DIV:    rdata[DIV_WIDTH-1:0] = div_q;
      REG_CS:     rdata[NUM_CS-1:0] = cs_q;
      REG_STATUS: begin
        rdata[STAT_BUSY] = eng_busy;
        rdata[STAT_DONE] = done_q;
        rdata[STAT_OVR]  = ovr_q;
      end
      default:    rdata = '0;
    endcase
  end

  // Single-cycle ack with the read data registered alongside it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
    end
  end

  // Configuration registers; CTRL and DIV are frozen while a frame runs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      div_q  <= DIV_WIDTH'(DIV_RESET);
      cs_q   <= '0;
    end else if (wr) begin
      if ((wb_adr_i == REG_CTRL) && !eng_busy) ctrl_q <= wb_dat_i[8:0] & CTRL_MASK;
      if ((wb_adr_i == REG_DIV) && !eng_busy)  div_q  <= wb_dat_i[DIV_WIDTH-1:0];
      if (wb_adr_i == REG_CS)                  cs_q   <= wb_dat_i[NUM_CS-1:0];
    end
  end

  // Sticky status flags; a completing frame beats a same-cycle clear of done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (eng_done)
        done_q <= 1'b1;
      else if (wr && (wb_adr_i == REG_STATUS) && wb_dat_i[STAT_DONE])
        done_q <= 1'b0;
      if (wr && (wb_adr_i == REG_DATA) && eng_busy)
        ovr_q <= 1'b1;
      else if (wr && (wb_adr_i == REG_STATUS) && wb_dat_i[STAT_OVR])
        ovr_q <= 1'b0;
    end
  end

  // Level interrupt, one cycle behind the done flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_o <= 1'b0;
    else          irq_o <= done_q & ctrl_q[CTRL_IRQ_EN];
  end

endmodule

// File: tb/tb_wb_spi_master_mc.sv
// Self-checking bench for wb_spi_master_mc: scoreboarded bus reads and
// per-frame SCK/MOSI/timing checks against a behavioural model.
`timescale 1ns/1ps
module tb_wb_spi_master_mc;

  localparam int NUM_CS    = 4;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_RESET = 24;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        wb_adr_i = '0;
  logic [31:0]       wb_dat_i = '0;
  logic [31:0]       wb_dat_o;
  logic [3:0]        wb_sel_i = 4'hF;
  logic              wb_we_i = 1'b0;
  logic              wb_cyc_i = 1'b0;
  logic              wb_stb_i = 1'b0;
  logic              wb_ack_o;
  logic              irq_o;
  logic              spi_sclk_o;
  logic              spi_mosi_o;
  logic              spi_miso_i;
  logic [NUM_CS-1:0] spi_cs_n_o;

  int miso_sel = 0;  // 0 loopback, 1 tied low, 2 tied high
  assign spi_miso_i = (miso_sel == 0) ? spi_mosi_o : (miso_sel == 2);

  always #5 clock = ~clock;

  wb_spi_master_mc #(
    .NUM_CS    (NUM_CS),
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_ack_o   (wb_ack_o),
    .irq_o      (irq_o),
    .spi_sclk_o (spi_sclk_o),
    .spi_mosi_o (spi_mosi_o),
    .spi_miso_i (spi_miso_i),
    .spi_cs_n_o (spi_cs_n_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] val;
    string       name;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  typedef struct {
    logic [31:0] seq;   // bit i = i-th bit expected on MOSI
    int          w;
    int          div;
    logic        cpol;
    logic        cpha;
  } frame_t;
  frame_t frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int width_of(input logic [1:0] enc);
    return (enc == 2'd1) ? 16 : (enc == 2'd2) ? 32 : 8;
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] exp_seq(input logic [31:0] tx, input int w, input logic lsb);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < w; i++) s[i] = lsb ? tx[i] : tx[w-1-i];
    return s;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic [2:0] a, input logic [31:0] d, input logic we);
    int k;
    @(posedge clock); #1;
    wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    k = 0;
    do begin
      @(posedge clock); #1;
      k++;
    end while (!wb_ack_o && k < 4);
    check("ack_latency", k, 1);
    @(posedge clock); #1;
    check("ack_pulse", wb_ack_o, 1'b0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    wb_xfer(a, d, 1'b1);
  endtask

  task automatic wb_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.val = exp;
    e.name = name;
    rd_q.push_back(e);
    wb_xfer(a, 32'h0, 1'b0);
  endtask

  // ---------------- read monitor ----------------
  initial begin : rd_mon
    rd_exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && wb_ack_o && !wb_we_i) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got 0x%0h expected none", wb_dat_o);
        end else begin
          e = rd_q.pop_front();
          check(e.name, wb_dat_o, e.val);
        end
      end
    end
  end

  // ---------------- frame monitor ----------------
  initial begin : frm_mon
    frame_t      cur;
    bit          in_frame;
    int          cyc, edges, first_edge, nb;
    logic        prev_sclk, prev_irq, leading;
    logic [31:0] seq;
    in_frame = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        in_frame = 1'b0;
        frame_q.delete();
      end else if (!in_frame) begin
        if (wb_ack_o && wb_we_i && wb_adr_i == 3'd0 && frame_q.size() > 0) begin
          cur = frame_q.pop_front();
          in_frame = 1'b1;
          cyc = 0; edges = 0; first_edge = -1; nb = 0; seq = '0;
          prev_sclk = spi_sclk_o;
          prev_irq = irq_o;
        end
      end else begin
        cyc++;
        if (spi_sclk_o !== prev_sclk) begin
          edges++;
          if (first_edge < 0) first_edge = cyc;
          leading = (spi_sclk_o != cur.cpol);
          if (leading != cur.cpha) begin
            if (nb < 32) seq[nb] = spi_mosi_o;
            nb++;
          end
        end
        prev_sclk = spi_sclk_o;
        if (irq_o && !prev_irq) begin
          check("first_edge", first_edge, cur.div + 1);
          check("busy_clocks", cyc - 1, (2 * cur.w + 1) * (cur.div + 1));
          check("sclk_edges", edges, 2 * cur.w);
          check("mosi_seq", seq, cur.seq);
          check("sclk_end_idle", spi_sclk_o, cur.cpol);
          in_frame = 1'b0;
        end else if (cyc > 4000) begin
          fail_now("frame_timeout");
          in_frame = 1'b0;
        end
        prev_irq = irq_o;
      end
    end
  end

  // ---------------- frame stimulus ----------------
  task automatic run_frame(input logic cpol, input logic cpha, input logic lsb,
                           input logic [1:0] wenc, input int div, input logic [31:0] tx,
                           input int msel, input bit extra);
    int          w, k;
    logic [31:0] mask, rx;
    logic [8:0]  ctrl;
    frame_t      f;
    w = width_of(wenc);
    mask = mask_of(w);
    miso_sel = msel;
    ctrl = {1'b1, 3'b000, wenc, lsb, cpol, cpha};
    wb_write(3'd1, {23'd0, ctrl});
    check("sclk_idle", spi_sclk_o, cpol);
    wb_write(3'd2, div);
    wb_write(3'd4, 32'h6);
    f.seq = exp_seq(tx, w, lsb); f.w = w; f.div = div; f.cpol = cpol; f.cpha = cpha;
    frame_q.push_back(f);
    wb_write(3'd0, tx);
    if (extra) begin
      wb_write(3'd0, ~tx);
      wb_write(3'd2, 32'h55);
      wb_read(3'd2, div, "div_locked");
      wb_read(3'd4, 32'h5, "status_busy_ovr");
    end
    k = 0;
    while (!irq_o && k < 5000) begin
      @(negedge clock);
      k++;
    end
    if (!irq_o) fail_now("irq_wait");
    rx = (msel == 0) ? (tx & mask) : (msel == 2) ? mask : 32'h0;
    wb_read(3'd0, rx, "rx_data");
    wb_read(3'd4, extra ? 32'h6 : 32'h2, "status_done");
    wb_write(3'd4, 32'h2);
    check("irq_clear", irq_o, 1'b0);
    if (extra) wb_write(3'd4, 32'h4);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] d;
    int          cnt, k;
    logic        prev;

    repeat (3) @(negedge clock);
    check("rst_sclk", spi_sclk_o, 1'b0);
    check("rst_mosi", spi_mosi_o, 1'b0);
    check("rst_cs_n", spi_cs_n_o, 4'hF);
    check("rst_irq", irq_o, 1'b0);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 32'h0);
    reset_n = 1'b1;

    wb_read(3'd2, DIV_RESET, "rst_div");
    wb_read(3'd1, 32'h0, "rst_ctrl");
    wb_read(3'd4, 32'h0, "rst_status");
    wb_read(3'd0, 32'h0, "rst_rx");
    wb_read(3'd3, 32'h0, "rst_cs");

    // Mode 0, MSB first, 8 bits, DIV=1, loopback.
    wb_write(3'd3, 32'h1);
    check("cs_n_one", spi_cs_n_o, 4'b1110);
    run_frame(1'b0, 1'b0, 1'b0, 2'd0, 1, 32'hA5, 0, 1'b0);
    // Mode 3, LSB first, 16 bits, DIV=0, MISO high.
    run_frame(1'b1, 1'b1, 1'b1, 2'd1, 0, 32'h1234, 2, 1'b0);
    // Mode 1, 32 bits, DIV=2, loopback.
    run_frame(1'b0, 1'b1, 1'b0, 2'd2, 2, 32'hDEADBEEF, 0, 1'b0);
    // Overrun and locked DIV during a frame.
    run_frame(1'b0, 1'b0, 1'b0, 2'd2, 1, $urandom, 0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom, $urandom_range(0, 2), 1'b0);
    end

    d = $urandom;
    wb_write(3'd1, d);
    wb_read(3'd1, d & 32'h11F, "ctrl_readback");
    wb_read(3'd6, 32'h0, "unmapped_6");
    wb_write(3'd7, 32'hFFFF_FFFF);
    wb_read(3'd7, 32'h0, "unmapped_7");
    wb_write(3'd3, 32'hF);
    check("cs_n_all", spi_cs_n_o, 4'h0);
    wb_read(3'd3, 32'hF, "cs_readback");

    // Reset in the middle of a frame.
    wb_write(3'd3, 32'h1);
    wb_write(3'd1, 32'h0);
    wb_write(3'd2, 32'd3);
    miso_sel = 0;
    wb_write(3'd0, 32'h3C);
    cnt = 0; k = 0; prev = spi_sclk_o;
    while (cnt < 5 && k < 500) begin
      @(negedge clock);
      if (spi_sclk_o !== prev) cnt++;
      prev = spi_sclk_o;
      k++;
    end
    check("edges_before_reset", cnt, 5);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sclk", spi_sclk_o, 1'b0);
    check("mid_rst_cs_n", spi_cs_n_o, 4'hF);
    check("mid_rst_mosi", spi_mosi_o, 1'b0);
    check("mid_rst_irq", irq_o, 1'b0);
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;
    wb_read(3'd2, DIV_RESET, "post_rst_div");
    wb_read(3'd4, 32'h0, "post_rst_status");
    wb_read(3'd1, 32'h0, "post_rst_ctrl");
    wb_read(3'd0, 32'h0, "post_rst_rx");

    repeat (4) @(negedge clock);
    check("rd_queue_empty", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
